// File: rtl/spi_xfer_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_xfer_queue: TX/RX byte FIFOs sequencing one SPI master transaction    |
// | per byte. Optional watchdog: define SPI_XFER_QUEUE_TIMEOUT_EN.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_xfer_queue #(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    spi_start,
  output logic [7:0]              spi_data_in,
  input  logic [7:0]              spi_data_out,
  input  logic                    spi_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  tx_level,
  output logic [$clog2(DEPTH):0]  rx_level,
  output logic                    timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [LW-1:0] C_FULL     = LW'(DEPTH);
  localparam logic [GW-1:0] C_GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_XFER = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_gap_cnt;

  logic [7:0]      r_tx_mem [DEPTH];
  logic [LW-1:0]   r_tx_wr;
  logic [LW-1:0]   r_tx_rd;
  logic [7:0]      r_rx_mem [DEPTH];
  logic [LW-1:0]   r_rx_wr;
  logic [LW-1:0]   r_rx_rd;

  logic            w_tx_push;
  logic            w_tx_pop;
  logic            w_rx_push;
  logic            w_rx_pop;

  assign tx_level  = r_tx_wr - r_tx_rd;
  assign rx_level  = r_rx_wr - r_rx_rd;
  assign tx_ready  = (tx_level != C_FULL);
  assign rx_valid  = (rx_level != '0);
  assign rx_data   = rx_valid ? r_rx_mem[r_rx_rd[AW-1:0]] : 8'h00;

  // LOAD is only entered with a non-empty TX FIFO, and RX space is checked
  // before leaving IDLE, so neither FIFO needs a guard on these strobes.
  assign w_tx_push = tx_valid && tx_ready;
  assign w_tx_pop  = (r_state == S_LOAD);
  assign w_rx_push = (r_state == S_XFER) && spi_done;
  assign w_rx_pop  = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + LW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + LW'(1);
      if (w_rx_push) r_rx_wr <= r_rx_wr + LW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= spi_data_out;
  end

`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo  = |TIMEOUT_CYCLES;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gap_cnt   <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= 8'h00;
      busy        <= 1'b0;
`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tx_level != '0 && rx_level != C_FULL) begin
            r_state <= S_LOAD;
            busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          spi_data_in <= r_tx_mem[r_tx_rd[AW-1:0]];
          spi_start   <= 1'b1;
          r_state     <= S_XFER;
`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
          r_tmo_cnt   <= '0;
`endif
        end
        S_XFER: begin
          // A done arriving on the expiry cycle still completes normally.
          if (spi_done) begin
            spi_start <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end
`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
          else if (r_tmo_cnt == C_TMO_LAST) begin
            spi_start   <= 1'b0;
            timeout_err <= 1'b1;
            r_gap_cnt   <= '0;
            r_state     <= S_GAP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
`endif
        end
        S_GAP: begin
          if (r_gap_cnt == C_GAP_LAST) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_xfer_queue: directed bench with SPI master model and scoreboards.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_spi_xfer_queue;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TMO   = 16;
  localparam int MLAT  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic [7:0] spi_data_out = 8'h00;
  logic       spi_done = 1'b0;
  logic       busy;
  logic [3:0] tx_level;
  logic [3:0] rx_level;
  logic       timeout_err;

  always #5 clk = ~clk;

  spi_xfer_queue #(
    .DEPTH          (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_done     (spi_done),
    .busy         (busy),
    .tx_level     (tx_level),
    .rx_level     (rx_level),
    .timeout_err  (timeout_err)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  int         n_xfers = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] key = 8'h00;
  logic       mute = 1'b0;
  int         mcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Master model: returns data_in ^ key after MLAT cycles of start high.
  always @(posedge clk) begin
    if (reset) begin
      mcnt     <= 0;
      spi_done <= 1'b0;
    end else begin
      spi_done <= 1'b0;
      if (!spi_start) begin
        mcnt <= 0;
      end else if (!spi_done && !mute) begin
        if (mcnt == MLAT - 1) begin
          spi_done     <= 1'b1;
          spi_data_out <= spi_data_in ^ key;
          mcnt         <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  // Monitor: transaction order/data, start-low gap, RX scoreboard on pops.
  initial begin
    logic       prev_start;
    logic       gap_valid;
    int         low_cnt;
    logic [7:0] xfer_data;
    prev_start = 1'b0;
    gap_valid  = 1'b0;
    low_cnt    = 0;
    xfer_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_start = 1'b0;
        gap_valid  = 1'b0;
        low_cnt    = 0;
      end else begin
        if (spi_start && !prev_start) begin
          n_xfers++;
          if (gap_valid) check("start_low_gap", low_cnt >= GAP + 1, 1);
          check("tx_sb_nonempty", tx_q.size() != 0, 1);
          if (tx_q.size() != 0) check("spi_data_in", spi_data_in, tx_q.pop_front());
          xfer_data = spi_data_in;
        end else if (!spi_start && prev_start) begin
          check("spi_data_in_stable", spi_data_in, xfer_data);
          gap_valid = 1'b1;
          low_cnt   = 1;
        end else if (!spi_start) begin
          low_cnt++;
        end
        if (rx_valid && rx_ready) begin
          check("rx_sb_nonempty", rx_q.size() != 0, 1);
          if (rx_q.size() != 0) check("rx_data", rx_data, rx_q.pop_front());
        end
        prev_start = spi_start;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic acc, input logic exp_rx);
    check("tx_ready", tx_ready, acc);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    if (acc) begin
      tx_q.push_back(b);
      if (exp_rx) rx_q.push_back(b ^ key);
    end
    #1;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int i;
    i = 0;
    while (i < maxc && !(busy === 1'b0 && tx_level === 4'd0 && rx_valid === 1'b0 && rx_q.size() == 0)) begin
      tick();
      i++;
    end
    check(tag, i < maxc, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    logic found;
    int   c;

    // Reset values
    tick();
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_data_in", spi_data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_busy", busy, 0);

    // Single byte: 0xA5 out, master returns 0x3C
    key = 8'h99;
    send(8'hA5, 1'b1, 1'b1);
    tx_valid = 1'b0;
    check("lat_n_tx_level", tx_level, 1);
    check("lat_n_start", spi_start, 0);
    tick();
    check("lat_n1_busy", busy, 1);
    check("lat_n1_start", spi_start, 0);
    tick();
    check("lat_n2_start", spi_start, 1);
    check("lat_n2_data_in", spi_data_in, 8'hA5);
    check("lat_n2_tx_level", tx_level, 0);
    for (int i = 0; i < 40 && rx_valid !== 1'b1; i++) tick();
    check("single_rx_valid", rx_valid, 1);
    check("single_rx_data", rx_data, 8'h3C);
    check("single_rx_level", rx_level, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    wait_idle("single_drain", 50);

    // Burst: fill TX to full, a further write is ignored
    key = 8'h00;
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 1'b1);
    check("burst_tx_level_full", tx_level, 8);
    send(8'hEE, 1'b0, 1'b1);
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    wait_idle("burst_drain", 400);

    // RX backpressure: 9 bytes, only 8 transactions fit
    rx_ready = 1'b0;
    key = 8'h5A;
    n0 = n_xfers;
    for (int i = 0; i < 9; i++) send(8'h40 + 8'(i), 1'b1, 1'b1);
    tx_valid = 1'b0;
    repeat (250) tick();
    check("bp_xfers_8", n_xfers - n0, 8);
    check("bp_rx_level", rx_level, 8);
    check("bp_tx_level", tx_level, 1);
    check("bp_busy", busy, 0);
    check("bp_start", spi_start, 0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat (40) tick();
    check("bp_xfers_9", n_xfers - n0, 9);
    check("bp_rx_level_after", rx_level, 8);
    check("bp_tx_level_after", tx_level, 0);

    // Simultaneous TX write + pop at level 4
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b1, 1'b1);
    tx_valid = 1'b0;
    check("sim_tx_level_pre", tx_level, 4);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    check("sim_load_busy", busy, 1);
    check("sim_tx_level_load", tx_level, 4);
    send(8'hD7, 1'b1, 1'b1);
    tx_valid = 1'b0;
    check("sim_tx_level_post", tx_level, 4);

    // Simultaneous RX push + pop at level 4
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (spi_done === 1'b1 && rx_level == 4'd4) begin
        found = 1'b1;
      end else begin
        rx_ready = (rx_level > 4'd4);
        tick();
      end
    end
    check("sim_rx_found", found, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("sim_rx_level_post", rx_level, 4);
    rx_ready = 1'b1;
    wait_idle("sim_drain", 400);

    // Reset mid-transaction
    key = 8'h00;
    send(8'h11, 1'b1, 1'b1);
    send(8'h22, 1'b1, 1'b1);
    tx_valid = 1'b0;
    for (int i = 0; i < 20 && spi_start !== 1'b1; i++) tick();
    check("mid_start_seen", spi_start, 1);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_start", spi_start, 0);
    check("mid_rst_tx_level", tx_level, 0);
    check("mid_rst_rx_level", rx_level, 0);
    check("mid_rst_busy", busy, 0);
    tx_q.delete();
    rx_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) tick();
    check("mid_no_rx", rx_valid, 0);
    check("mid_idle", busy, 0);
    send(8'h33, 1'b1, 1'b1);
    tx_valid = 1'b0;
    wait_idle("mid_recover", 60);

`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
    // Watchdog: master never answers the first byte
    mute = 1'b1;
    send(8'h77, 1'b1, 1'b0);
    send(8'h88, 1'b1, 1'b1);
    tx_valid = 1'b0;
    for (int i = 0; i < 20 && spi_start !== 1'b1; i++) tick();
    check("tmo_start_seen", spi_start, 1);
    c = 0;
    while (spi_start === 1'b1 && c < 100) begin
      tick();
      c++;
    end
    mute = 1'b0;
    check("tmo_cycles", c, TMO);
    check("tmo_err_set", timeout_err, 1);
    wait_idle("tmo_next_byte", 80);
    check("tmo_err_sticky", timeout_err, 1);
`else
    c = 0;
    check("timeout_err_tied", timeout_err, c);
`endif

    check("sb_rx_empty", rx_q.size(), 0);
    check("sb_tx_empty", tx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
